phi2_recover: RTL and testbench

Receive-side counterpart of the internal clock-enable divider: recovers a one-cycle clock-enable pulse from an external, asynchronous PHI2-style square wave (nominally ~1 MHz) so the SID core can run from a host bus clock instead of the local divider. The block synchronizes the input, detects its rising edges, and measures the period in `clk` cycles. It reports lock when the period is stable and flags timeout when the input stops. It sits between the chip's PHI2 pin and every block that consumes `clk_en`.

---
 rtl/sid_pkg.sv | 14 +
 rtl/sync_edge.sv | 27 ++
 rtl/phi2_recover.sv | 130 +++++++++++++
 tb/tb_phi2_recover.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Definitions shared by the SID clocking blocks: PHI2 recovery state
// encoding and the default input-timeout length.
package sid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_LOCKED,
        ST_TIMEOUT
    } phi2_state_t;

    localparam int PHI2_TIMEOUT = 200;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a
// rising-edge detector; rise is a one-cycle pulse decoded from flops only.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev;

    always_ff @(posedge clk, negedge n_reset) begin
        if (!n_reset) begin
            sync_chain <= '0;
            prev       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
            prev       <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign rise = sync_chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/phi2_recover.sv
// Recovers a clk_en pulse from an external PHI2 square wave, measures its
// period in clk cycles, and reports lock / loss-of-input status.
module phi2_recover
    import sid_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 8,
    parameter int TIMEOUT     = PHI2_TIMEOUT,
    parameter int LOCK_COUNT  = 4,
    parameter int TOLERANCE   = 1
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                phi2_in,
    output logic                clk_en_out,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid,
    output logic                locked,
    output logic                timeout
);

    localparam int                  MATCH_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [PERIOD_W-1:0] CNT_MAX   = PERIOD_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0]  MATCH_MAX = MATCH_W'(LOCK_COUNT);

    function automatic logic in_tolerance(input logic [PERIOD_W-1:0] a,
                                          input logic [PERIOD_W-1:0] b);
        logic signed [PERIOD_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        if (diff < 0)
            diff = -diff;
        return diff <= $signed((PERIOD_W + 1)'(TOLERANCE));
    endfunction

    function automatic logic [MATCH_W-1:0] match_inc(input logic [MATCH_W-1:0] m);
        return (m == MATCH_MAX) ? m : m + 1'b1;
    endfunction

    logic                rise;
    logic [PERIOD_W-1:0] cnt;
    phi2_state_t         state_q, state_d;
    logic                ref_valid_q, ref_valid_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [PERIOD_W-1:0] ref_period_q;
    logic                measure;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .n_reset (n_reset),
        .async_in(phi2_in),
        .rise    (rise)
    );

    assign clk_en_out = rise;

    // Cycles since the last rise; holds at TIMEOUT once the input stops.
    always_ff @(posedge clk, negedge n_reset) begin
        if (!n_reset)
            cnt <= '0;
        else if (rise)
            cnt <= PERIOD_W'(1);
        else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk, negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            ref_valid_q  <= 1'b0;
            match_q      <= '0;
            ref_period_q <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_valid_q  <= ref_valid_d;
            match_q      <= match_d;
            period_valid <= measure;
            if (measure) begin
                period_out   <= cnt;
                ref_period_q <= cnt;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ref_valid_d = ref_valid_q;
        match_d     = match_q;
        measure     = 1'b0;
        case (state_q)
            // First edge after reset or dropout only restarts the count.
            ST_IDLE, ST_TIMEOUT: begin
                if (rise) begin
                    state_d     = ST_SEARCH;
                    ref_valid_d = 1'b0;
                end
            end
            ST_SEARCH, ST_LOCKED: begin
                if (rise) begin
                    measure = 1'b1;
                    if (!ref_valid_q) begin
                        ref_valid_d = 1'b1;
                        match_d     = '0;
                    end else if (in_tolerance(cnt, ref_period_q)) begin
                        match_d = match_inc(match_q);
                    end else begin
                        match_d = '0;
                        state_d = ST_SEARCH;
                    end
                    if (state_q == ST_SEARCH && match_d == MATCH_MAX)
                        state_d = ST_LOCKED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // An edge in the same cycle as the saturated count still counts.
        if (cnt == CNT_MAX && !rise) begin
            state_d     = ST_TIMEOUT;
            match_d     = '0;
            ref_valid_d = 1'b0;
        end
    end

    assign locked  = (state_q == ST_LOCKED);
    assign timeout = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_phi2_recover.sv
// Bench for phi2_recover: event-level reference model (pulse timestamps,
// period differences, match runs) compared every cycle, plus scenario checks.
module tb_phi2_recover;

    localparam int T   = 200;
    localparam int L   = 4;
    localparam int TOL = 1;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       phi2 = 1'b0;
    logic       en2, pv2, lk2, to2;
    logic [7:0] per2;
    logic       en3, pv3, lk3, to3;
    logic [7:0] per3;

    always #5 clk = ~clk;

    phi2_recover #(.SYNC_STAGES(2), .PERIOD_W(8), .TIMEOUT(T), .LOCK_COUNT(L), .TOLERANCE(TOL)) dut (
        .clk(clk), .n_reset(n_reset), .phi2_in(phi2), .clk_en_out(en2),
        .period_out(per2), .period_valid(pv2), .locked(lk2), .timeout(to2));

    phi2_recover #(.SYNC_STAGES(3), .PERIOD_W(8), .TIMEOUT(T), .LOCK_COUNT(L), .TOLERANCE(TOL)) dut3 (
        .clk(clk), .n_reset(n_reset), .phi2_in(phi2), .clk_en_out(en3),
        .period_out(per3), .period_valid(pv3), .locked(lk3), .timeout(to3));

    int total = 0;
    int bad   = 0;
    bit stim[$];

    // Reference model state: timestamps in clk edges, not counters.
    bit         h1, h2, m_en, m_pv, m_locked, m_timeout, synced, have_ref;
    int         run, m_ref, cyc, last_end;
    logic [7:0] m_period;

    task automatic model_reset();
        h1 = 0; h2 = 0; m_en = 0; m_pv = 0; m_period = '0;
        m_locked = 0; m_timeout = 0; synced = 0; have_ref = 0;
        run = 0; m_ref = 0;
        last_end = cyc + 1;
    endtask

    task automatic model_step();
        int p, d;
        if (!n_reset) begin
            model_reset();
            return;
        end
        cyc++;
        m_pv = 0;
        if (m_en) begin
            if (!synced) begin
                synced    = 1;
                have_ref  = 0;
                m_timeout = 0;
            end else begin
                p        = cyc - last_end;
                m_period = 8'(p);
                m_pv     = 1;
                d        = (p > m_ref) ? p - m_ref : m_ref - p;
                if (!have_ref) begin
                    have_ref = 1;
                    run      = 0;
                end else if (d <= TOL) begin
                    run = (run < L) ? run + 1 : L;
                end else begin
                    run      = 0;
                    m_locked = 0;
                end
                if (run == L) m_locked = 1;
                m_ref = p;
            end
            last_end = cyc;
        end else if (cyc - last_end >= T) begin
            m_timeout = 1; m_locked = 0; synced = 0; have_ref = 0; run = 0;
        end
        m_en = h1 & ~h2;
        h2   = h1;
        h1   = phi2;
    endtask

    task automatic cycle(input bit v);
        @(posedge clk);
        model_step();
        #1 phi2 = v;
        @(negedge clk);
    endtask

    task automatic add_wave(input int hi, input int lo);
        for (int k = 0; k < hi; k++) stim.push_back(1'b1);
        for (int k = 0; k < lo; k++) stim.push_back(1'b0);
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            if (en2 !== 1'b0 || pv2 !== 1'b0 || per2 !== 8'd0 || lk2 !== 1'b0 || to2 !== 1'b0) begin
                bad++;
                $display("FAIL reset_state i=%0d got en%b pv%b per%0d lk%b to%b want all zero", i, en2, pv2, per2, lk2, to2);
            end
            total++;
        end
        n_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0);
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL reset_release i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
        end
    endtask

    task automatic test_sync_latency();
        bit v[5]  = '{1, 1, 0, 0, 0};
        bit e2[5] = '{0, 0, 1, 0, 0};
        bit e3[5] = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            cycle(v[i]);
            if (en2 !== e2[i] || en3 !== e3[i]) begin
                bad++;
                $display("FAIL sync_latency i=%0d got en2=%b en3=%b want en2=%b en3=%b", i, en2, en3, e2[i], e3[i]);
            end
            total++;
            if (pv3 !== 1'b0 || per3 !== 8'd0 || lk3 !== 1'b0 || to3 !== 1'b0) begin
                bad++;
                $display("FAIL sync3_first_edge i=%0d got pv%b per%0d lk%b to%b want all zero", i, pv3, per3, lk3, to3);
            end
            total++;
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL latency_model i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
        end
    endtask

    task automatic test_lock();
        int pulses = 0;
        bit prev_en = 0, seen = 0;
        n_reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0);
        n_reset = 1'b1;
        stim.delete();
        for (int w = 0; w < 10; w++) add_wave(8, 8);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL lock_model i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
            if (lk2 === 1'b1 && !seen) begin
                seen = 1;
                if (pulses !== 6 || !prev_en) begin
                    bad++;
                    $display("FAIL lock_time got pulses=%0d prev_en=%b want pulses=6 prev_en=1", pulses, prev_en);
                end
                total++;
            end
            if (en2 === 1'b1) pulses++;
            prev_en = en2;
        end
        if (!seen || per2 !== 8'd16) begin
            bad++;
            $display("FAIL lock_final got locked_seen=%b period=%0d want 1 and 16", seen, per2);
        end
        total++;
    endtask

    task automatic test_jitter_step();
        int lj, pulses = 0, fell_p = -1, rose_p = -1;
        bit prev_lk = 1;
        stim.delete();
        for (int w = 0; w < 10; w++) add_wave(8, 8 + int'($urandom_range(0, 1)));
        lj = stim.size();
        for (int w = 0; w < 7; w++) add_wave(10, 10);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL jitter_model i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
            if (i < lj) begin
                if (lk2 !== 1'b1) begin
                    bad++;
                    $display("FAIL jitter_hold i=%0d got locked=%b want 1", i, lk2);
                end
                total++;
            end
            if (prev_lk && lk2 === 1'b0 && fell_p < 0) fell_p = pulses;
            if (!prev_lk && lk2 === 1'b1 && fell_p >= 0 && rose_p < 0) rose_p = pulses;
            if (en2 === 1'b1) pulses++;
            prev_lk = lk2;
        end
        if (fell_p < 0 || rose_p - fell_p !== 4) begin
            bad++;
            $display("FAIL step_relock got fell=%0d rose=%0d want rose-fell=4", fell_p, rose_p);
        end
        total++;
    endtask

    task automatic test_random();
        stim.delete();
        for (int w = 0; w < 30; w++)
            add_wave(int'($urandom_range(2, 12)), int'($urandom_range(2, 12)));
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL random_model i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
        end
    endtask

    task automatic test_timeout();
        int last_i = 0, resume_pulses = 0;
        bit prev_to = 0, prev_en = 0, seen_to = 0, seen_pv = 0;
        stim.delete();
        for (int w = 0; w < 8; w++) add_wave(8, 8);
        add_wave(0, 260);
        for (int w = 0; w < 3; w++) add_wave(8, 8);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL timeout_model i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
            if (to2 === 1'b1 && !prev_to) begin
                seen_to = 1;
                if (i - last_i !== T + 1 || lk2 !== 1'b0 || per2 !== 8'd16) begin
                    bad++;
                    $display("FAIL timeout_rise got delay=%0d locked=%b period=%0d want delay=%0d locked=0 period=16", i - last_i, lk2, per2, T + 1);
                end
                total++;
            end
            if (to2 === 1'b0 && prev_to) begin
                if (!prev_en || resume_pulses !== 1) begin
                    bad++;
                    $display("FAIL timeout_clear got prev_en=%b pulses=%0d want 1 and 1", prev_en, resume_pulses);
                end
                total++;
            end
            if (seen_to && pv2 === 1'b1 && !seen_pv) begin
                seen_pv = 1;
                if (resume_pulses !== 2 || per2 !== 8'd16) begin
                    bad++;
                    $display("FAIL resume_valid got pulses=%0d period=%0d want 2 and 16", resume_pulses, per2);
                end
                total++;
            end
            if (en2 === 1'b1) begin
                last_i = i;
                if (seen_to) resume_pulses++;
            end
            prev_to = to2;
            prev_en = en2;
        end
        if (!seen_to || !seen_pv) begin
            bad++;
            $display("FAIL timeout_seen got timeout=%b resume_valid=%b want 1 and 1", seen_to, seen_pv);
        end
        total++;
    endtask

    task automatic test_period_max();
        int n200 = 0;
        bit seen_to = 0;
        stim.delete();
        add_wave(100, 100);
        add_wave(100, 100);
        add_wave(8, 8);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL max_model i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
            if (to2 === 1'b1) seen_to = 1;
            if (pv2 === 1'b1 && per2 === 8'd200) n200++;
        end
        if (seen_to || n200 !== 2) begin
            bad++;
            $display("FAIL period_200 got timeout_seen=%b valid200=%0d want 0 and 2", seen_to, n200);
        end
        total++;
        stim.delete();
        add_wave(100, 101);
        add_wave(8, 8);
        add_wave(8, 8);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL over_model i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
            if (to2 === 1'b1) seen_to = 1;
        end
        if (!seen_to) begin
            bad++;
            $display("FAIL period_201 got timeout_seen=0 want 1");
        end
        total++;
    endtask

    task automatic test_reset_mid_lock();
        int pulses = 0;
        bit prev_en = 0, seen = 0;
        stim.delete();
        for (int w = 0; w < 8; w++) add_wave(8, 8);
        stim.push_back(1'b1);
        stim.push_back(1'b1);
        stim.push_back(1'b1);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL prelock_model i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
        end
        if (lk2 !== 1'b1) begin
            bad++;
            $display("FAIL prelock got locked=%b want 1", lk2);
        end
        total++;
        n_reset = 1'b0;
        phi2    = 1'b0;
        model_reset();
        #1;
        if (en2 !== 1'b0 || pv2 !== 1'b0 || per2 !== 8'd0 || lk2 !== 1'b0 || to2 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got en%b pv%b per%0d lk%b to%b want all zero", en2, pv2, per2, lk2, to2);
        end
        total++;
        for (int i = 0; i < 3; i++) cycle(1'b0);
        n_reset = 1'b1;
        stim.delete();
        for (int w = 0; w < 9; w++) add_wave(8, 8);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (en2 !== m_en || pv2 !== m_pv || per2 !== m_period || lk2 !== m_locked || to2 !== m_timeout) begin
                bad++;
                $display("FAIL relock_model i=%0d got en%b pv%b per%0d lk%b to%b want en%b pv%b per%0d lk%b to%b", i, en2, pv2, per2, lk2, to2, m_en, m_pv, m_period, m_locked, m_timeout);
            end
            total++;
            if (lk2 === 1'b1 && !seen) begin
                seen = 1;
                if (pulses !== 6 || !prev_en) begin
                    bad++;
                    $display("FAIL relock_time got pulses=%0d prev_en=%b want pulses=6 prev_en=1", pulses, prev_en);
                end
                total++;
            end
            if (en2 === 1'b1) pulses++;
            prev_en = en2;
        end
        if (!seen) begin
            bad++;
            $display("FAIL relock_seen got locked never 1 want 1");
        end
        total++;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        test_reset();
        test_sync_latency();
        test_lock();
        test_jitter_step();
        test_random();
        test_timeout();
        test_period_max();
        test_reset_mid_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
